// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM between N_REQ address units and routes each returned word to its issuer.
// Optional SPRITE_ARB_PRIO_EN: requester 0 always wins; the other requesters are served round-robin.
module sprite_rom_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 12,
   parameter int ROM_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        gnt,
   output logic                    rom_en,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_dout,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    busy
);
   localparam int TAG_W = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ);
`ifdef SPRITE_ARB_PRIO_EN
   localparam int PTR_LO = 1;
`else
   localparam int PTR_LO = 0;
`endif
   localparam int               RR_SPAN = N_REQ - PTR_LO;
   localparam logic [TAG_W-1:0] PTR_RST = TAG_W'(PTR_LO);
   localparam logic [TAG_W-1:0] LAST    = TAG_W'(N_REQ - 1);

   logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              rom_en_q, rom_en_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ROM_LAT:0]  tv_q, tv_d;
   logic [TAG_W-1:0]  tt_q [ROM_LAT+1];
   logic [TAG_W-1:0]  tt_d [ROM_LAT+1];
   logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              win_ok;
   logic [TAG_W-1:0]  win_idx;
   logic [TAG_W-1:0]  cand;
   logic              xfer;

   always_comb begin
      win_ok  = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < RR_SPAN; k++) begin
         cand = TAG_W'((int'(rr_ptr_q) - PTR_LO + k) % RR_SPAN + PTR_LO);
         if (!win_ok && req[cand]) begin
            win_ok  = 1'b1;
            win_idx = cand;
         end
      end
`ifdef SPRITE_ARB_PRIO_EN
      if (req[0]) begin
         win_ok  = 1'b1;
         win_idx = '0;
      end
`endif
   end

   // Reset masks the grant so a request coinciding with reset never transfers.
   assign xfer = win_ok & ~reset;

   always_comb begin
      gnt = '0;
      if (xfer) gnt[win_idx] = 1'b1;
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rom_en_d   = xfer;
      rom_addr_d = rom_addr_q;
      tv_d       = {tv_q[ROM_LAT-1:0], xfer};
      tt_d[0]    = win_idx;
      for (int s = 1; s <= ROM_LAT; s++) tt_d[s] = tt_q[s-1];
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (xfer) begin
         rom_addr_d = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
`ifdef SPRITE_ARB_PRIO_EN
         if (win_idx != '0)
            rr_ptr_d = (win_idx == LAST) ? PTR_RST : win_idx + TAG_W'(1);
`else
         rr_ptr_d = (win_idx == LAST) ? PTR_RST : win_idx + TAG_W'(1);
`endif
      end
      if (tv_q[ROM_LAT]) begin
         rsp_valid_d[tt_q[ROM_LAT]] = 1'b1;
         rsp_data_d                 = rom_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q    <= PTR_RST;
         rom_en_q    <= 1'b0;
         rom_addr_q  <= '0;
         tv_q        <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         for (int s = 0; s <= ROM_LAT; s++) tt_q[s] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rom_en_q    <= rom_en_d;
         rom_addr_q  <= rom_addr_d;
         tv_q        <= tv_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         for (int s = 0; s <= ROM_LAT; s++) tt_q[s] <= tt_d[s];
      end
   end

   assign rom_en    = rom_en_q;
   assign rom_addr  = rom_addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = rom_en_q | (|tv_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed scenarios followed by random traffic with a 3-cycle ROM.
// Honours SPRITE_ARB_PRIO_EN in its reference model.
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;
   localparam int N   = 4;
   localparam int AW  = 16;
   localparam int DW  = 12;
   localparam int LAT = 3;
`ifdef SPRITE_ARB_PRIO_EN
   localparam int RST_PTR = 1;
`else
   localparam int RST_PTR = 0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    gnt;
   logic            rom_en;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_dout;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            busy;

   sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      logic [31:0] t;
      t = {16'd0, a} * 32'd40503 + 32'h1234;
      return t[27:16] ^ t[11:0];
   endfunction

   // pipelined ROM: address sampled on rom_en, word appears LAT edges later
   logic [DW-1:0] rom_pipe [LAT];
   always @(posedge clk) begin
      if (rom_en) rom_pipe[0] <= rom_fn(rom_addr);
      for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
   end
   assign rom_dout = rom_pipe[LAT-1];

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t sb[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // reference model state
   int            m_ptr  = RST_PTR;
   logic          m_en   = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [N-1:0]  last_gnt = '0;

   function automatic int model_winner(input logic [N-1:0] r);
`ifdef SPRITE_ARB_PRIO_EN
      if (r[0]) return 0;
      for (int k = 0; k < N - 1; k++)
         if (r[1 + (m_ptr - 1 + k) % (N - 1)]) return 1 + (m_ptr - 1 + k) % (N - 1);
`else
      for (int k = 0; k < N; k++)
         if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
      return -1;
   endfunction

   function automatic logic model_busy();
      foreach (sb[j]) if (sb[j].due > cyc) return 1'b1;
      return 1'b0;
   endfunction

   // Called just after a rising edge: drives one cycle of inputs, checks, then advances the model.
   task automatic run_cycle(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic rst);
      int           w;
      logic [N-1:0] exp_g;
      exp_t         e;
      req = r; req_addr = a; reset = rst;
      @(negedge clk);
      w = model_winner(r);
      exp_g = (rst || w < 0) ? '0 : (N'(1) << w);
      check("gnt", gnt, exp_g);
      check("rom_en", rom_en, m_en);
      check("rom_addr", rom_addr, m_addr);
      check("busy", busy, model_busy());
      last_gnt = exp_g;
      if (exp_g != '0) begin
         e.idx = w; e.data = rom_fn(a[w*AW +: AW]); e.due = cyc + 2 + LAT;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      if (rst) begin
         m_ptr = RST_PTR; m_en = 1'b0; m_addr = '0;
         sb.delete();
      end else begin
         m_en = (exp_g != '0);
         if (m_en) begin
            m_addr = a[w*AW +: AW];
`ifdef SPRITE_ARB_PRIO_EN
            if (w != 0) m_ptr = w % (N - 1) + 1;
`else
            m_ptr = (w + 1) % N;
`endif
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle('0, '0, 1'b0);
   endtask

   // response monitor
   exp_t mon_e;
   always @(negedge clk) begin
      if (rsp_valid !== '0) begin
         if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
         else begin
            mon_e = sb.pop_front();
            check("rsp_valid", rsp_valid, N'(1) << mon_e.idx);
            check("rsp_data", rsp_data, mon_e.data);
            check("rsp_cycle", cyc, mon_e.due);
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         check("rsp_missing", rsp_valid, N'(1) << mon_e.idx);
      end
   end

   logic [N*AW-1:0] a;
   logic [N-1:0]    r;
   logic            rst;

   initial begin
      reset = 1'b1; req = '0; req_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      run_cycle('0, '0, 1'b1);
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;

      // single requester held three cycles
      a = '0; a[2*AW +: AW] = 16'h0123;
      repeat (3) run_cycle(4'b0100, a, 1'b0);
      idle(LAT + 3);

      // all requesters active: rotation and wrap
      for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(16 * i);
      repeat (9) run_cycle(4'b1111, a, 1'b0);
      idle(LAT + 3);

      // requester 0 joins a running 1/2 sequence
      a = '0; a[0 +: AW] = 16'h0A00; a[AW +: AW] = 16'h0A11; a[2*AW +: AW] = 16'h0A22;
      repeat (2) run_cycle(4'b0110, a, 1'b0);
      repeat (4) run_cycle(4'b0111, a, 1'b0);
      idle(LAT + 3);

      // reset with reads in flight
      for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(16'h0B00 + i);
      repeat (2) run_cycle(4'b1111, a, 1'b0);
      run_cycle(4'b1111, a, 1'b1);
      run_cycle(4'b1110, a, 1'b0);
      idle(LAT + 3);

      // requester 1 withdraws before being granted
      a = '0; a[0 +: AW] = 16'h0C00; a[AW +: AW] = 16'hBEEF;
      run_cycle(4'b0011, a, 1'b0);
      run_cycle(4'b0001, a, 1'b0);
      idle(LAT + 3);

      // random traffic with withdrawals and occasional reset
      r = '0; a = '0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (r[i] && !last_gnt[i]) begin
               if ($urandom_range(0, 9) == 0) r[i] = 1'b0;
            end else if ($urandom_range(0, 2) != 0) begin
               r[i] = 1'b1;
               a[i*AW +: AW] = AW'($urandom);
            end else r[i] = 1'b0;
         end
         if ($urandom_range(0, 15) == 0) r = '0;
         rst = ($urandom_range(0, 399) == 0);
         run_cycle(r, a, rst);
      end
      idle(LAT + 4);
      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
